spi_clk_gen: RTL and testbench

SPI_CLK_GEN -- requirements
Module: spi_clk_gen

---
 rtl/spi_clk_gen_if.sv | 19 +
 rtl/spi_clk_gen.sv | 96 +++++++++
 tb/tb_spi_clk_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/spi_clk_gen_if.sv
// spi_clk_gen_if: control inputs and clock/strobe outputs of the SPI clock generator
interface spi_clk_gen_if #(parameter int DIV_W = 8, parameter int CNT_W = 16);
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] nbits;
  logic cpol;
  logic cpha;
  logic start;
  logic abort;
  logic sck;
  logic sck_n;
  logic busy;
  logic sample;
  logic shift;
  logic done;
  modport master(output div, nbits, cpol, cpha, start, abort,
                 input sck, sck_n, busy, sample, shift, done);
  modport slave(input div, nbits, cpol, cpha, start, abort,
                output sck, sck_n, busy, sample, shift, done);
endinterface

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: programmable SPI serial clock with sample/shift strobes and guard time
module spi_clk_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input logic clk_in1,
  input logic reset,
  spi_clk_gen_if.slave b
);
  typedef enum logic [1:0] {IDLE, RUN, GUARD} state_t;
  state_t state_q, state_d;
  logic [DIV_W-1:0] hcnt_q, hcnt_d, div_q, div_d;
  logic [CNT_W:0] ecnt_q, ecnt_d, ecnt_n;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d;
  logic sck_q, sck_d, sample_q, sample_d, shift_q, shift_d, done_q, done_d;
  logic wrap;
  assign wrap = hcnt_q == div_q;
  assign ecnt_n = ecnt_q + 1'b1;
  assign b.sck = sck_q;
  assign b.sck_n = ~sck_q;
  assign b.busy = state_q != IDLE;
  assign b.sample = sample_q;
  assign b.shift = shift_q;
  assign b.done = done_q;
  // next-state: accept transfers, divide the clock, count edges, time the guard
  always_comb begin
    state_d = state_q;
    hcnt_d = hcnt_q;
    ecnt_d = ecnt_q;
    div_d = div_q;
    nbits_d = nbits_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    sck_d = sck_q;
    sample_d = 1'b0;
    shift_d = 1'b0;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      sck_d = b.cpol;
      if (b.start && !b.abort && |b.nbits) begin
        state_d = RUN;
        div_d = b.div;
        nbits_d = b.nbits;
        cpol_d = b.cpol;
        cpha_d = b.cpha;
        hcnt_d = '0;
        ecnt_d = '0;
      end
    end else if (b.abort) begin
      state_d = IDLE;
      sck_d = cpol_q;
    end else if (state_q == RUN) begin
      hcnt_d = wrap ? '0 : hcnt_q + 1'b1;
      if (wrap) begin
        sck_d = ~sck_q;
        ecnt_d = ecnt_n;
        sample_d = ecnt_n[0] ^ cpha_q;
        shift_d = ~(ecnt_n[0] ^ cpha_q);
        state_d = ecnt_n == {nbits_q, 1'b0} ? GUARD : RUN;
      end
    end else begin
      hcnt_d = wrap ? '0 : hcnt_q + 1'b1;
      state_d = wrap ? IDLE : GUARD;
      done_d = wrap;
    end
  end
  // state and output registers
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      state_q <= IDLE;
      hcnt_q <= '0;
      ecnt_q <= '0;
      div_q <= '0;
      nbits_q <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      sck_q <= 1'b0;
      sample_q <= 1'b0;
      shift_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q <= hcnt_d;
      ecnt_q <= ecnt_d;
      div_q <= div_d;
      nbits_q <= nbits_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      sck_q <= sck_d;
      sample_q <= sample_d;
      shift_q <= shift_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_spi_clk_gen.sv
// tb_spi_clk_gen: directed checks of the SPI clock generator against a cycle model
module tb_spi_clk_gen;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  spi_clk_gen_if #(.DIV_W(8), .CNT_W(8)) b();
  spi_clk_gen #(.DIV_W(8), .CNT_W(8)) dut(.clk_in1(clk), .reset(rst), .b(b));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [5:0] obs();
    return {b.sck, b.sck_n, b.busy, b.sample, b.shift, b.done};
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic run(input int d, input int n, input int pol, input int pha,
                     input int total, input int ab_k, input int ms_k);
    int p, e2, fin, t;
    logic tog, s, ph;
    logic [5:0] ex;
    p = d + 1;
    e2 = 2 * n;
    fin = (2 * n + 1) * p;
    b.div = 8'(d);
    b.nbits = 8'(n);
    b.cpol = pol[0];
    b.cpha = pha[0];
    b.start = 1'b1;
    step();
    b.start = 1'b0;
    for (int k = 1; k <= total; k++) begin
      if (k == ab_k) b.abort = 1'b1;
      if (k == ms_k) begin
        b.start = 1'b1;
        b.div = 8'(d + 2);
        b.nbits = 8'(n + 3);
        b.cpha = ~pha[0];
      end
      step();
      b.abort = 1'b0;
      b.start = 1'b0;
      b.div = 8'(d);
      b.nbits = 8'(n);
      b.cpha = pha[0];
      t = k / p;
      if (t > e2) t = e2;
      tog = (k % p == 0) && (k / p <= e2);
      s = pol[0] ^ t[0];
      ph = t[0] ^ pha[0];
      ex = {s, ~s, k < fin, tog && ph, tog && !ph, k == fin};
      if (ab_k > 0 && k >= ab_k) ex = {pol[0], ~pol[0], 4'b0000};
      chk($sformatf("xfer d=%0d n=%0d k=%0d", d, n, k), 32'(obs()), 32'(ex));
    end
  endtask
  initial begin
    rst = 1'b1;
    b.div = '0;
    b.nbits = '0;
    b.cpol = 1'b1;
    b.cpha = 1'b0;
    b.start = 1'b0;
    b.abort = 1'b0;
    step();
    step();
    chk("reset", 32'(obs()), 32'(6'b010000));
    rst = 1'b0;
    step();
    chk("release_cpol1", 32'(obs()), 32'(6'b100000));
    b.cpol = 1'b0;
    step();
    chk("idle_track_cpol0", 32'(obs()), 32'(6'b010000));
    run(1, 8, 0, 0, 40, 0, 0);
    run(0, 1, 1, 1, 6, 0, 0);
    run(1, 8, 0, 0, 46, 6, 0);
    run(3, 1, 0, 1, 20, 10, 0);
    b.nbits = '0;
    b.start = 1'b1;
    step();
    b.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("nbits0_ignored", 32'(obs()), 32'(6'b010000));
    end
    b.nbits = 8'd4;
    b.start = 1'b1;
    b.abort = 1'b1;
    step();
    b.start = 1'b0;
    b.abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("abort_beats_start", 32'(obs()), 32'(6'b010000));
    end
    run(2, 3, 0, 0, 30, 0, 5);
    run(2, 4, 1, 0, 4, 0, 0);
    rst = 1'b1;
    step();
    chk("reset_mid_run", 32'(obs()), 32'(6'b010000));
    step();
    chk("reset_hold", 32'(obs()), 32'(6'b010000));
    rst = 1'b0;
    step();
    chk("reset_release_cpol", 32'(obs()), 32'(6'b100000));
    step();
    chk("post_reset_no_done", 32'(obs()), 32'(6'b100000));
    run(0, 255, 0, 1, 515, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
